// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, default
// widths, the default bubble pattern and field positions inside ctrl/data.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam int CTRL_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 128;
    localparam int CNT_W_DEFAULT  = 8;

    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE_DEFAULT = '0;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 32;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_CTRL_W = 16;
    localparam int EX_MEM_DATA_W = 128;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;

    // Control field layout shared by every stage that carries it.
    localparam int CTRL_REG_WR_BIT = 0;
    localparam int CTRL_MEM_WR_BIT = 1;
    localparam int CTRL_BRANCH_BIT = 2;
    localparam int CTRL_JUMP_BIT   = 3;
    localparam int CTRL_ALUOP_LSB  = 4;
    localparam int CTRL_ALUOP_W    = 4;

    // Data field layout for the wide ID/EX word.
    localparam int DATA_PC_LSB  = 0;
    localparam int DATA_IMM_LSB = 32;
    localparam int DATA_RS1_LSB = 64;
    localparam int DATA_RS2_LSB = 96;
    localparam int DATA_RD_LSB  = 123;
    localparam int DATA_REG_W   = 5;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream valid/ready channels of one pipeline stage.
// master = producer/consumer side, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid register and EMPTY/FULL/SKID occupancy FSM; tells the stage
// when to load its output from the input or from the skid entry.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              load_in,
    output logic              load_skid,
    output logic              clear_out,
    output logic [CTRL_W-1:0] skid_ctrl,
    output logic [DATA_W-1:0] skid_data
);
    pipe_state_e state_q, state_d;
    logic        in_ready_q;
    logic        accept;
    logic        skid_we;

    assign accept   = in_valid & in_ready_q;
    assign in_ready = in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        clear_out = 1'b0;
        skid_we   = 1'b0;
        if (flush) begin
            state_d   = EMPTY;
            clear_out = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        load_in = 1'b1;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (accept && out_ready) begin
                        load_in = 1'b1;
                    end else if (accept) begin
                        skid_we = 1'b1;
                        state_d = SKID;
                    end else if (out_ready) begin
                        clear_out = 1'b1;
                        state_d   = EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: the skid payload has no reset; whether it is meaningful is tracked by state_q alone.
    always_ff @(posedge clk) begin
        if (skid_we) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with flush-to-bubble and a saturating stall
// counter. Define PIPE_STAGE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W      = CTRL_W_DEFAULT,
    parameter int                DATA_W      = DATA_W_DEFAULT,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);
    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_q;
    logic              load_in;
    logic              load_skid;
    logic              clear_out;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ctrl   (bus.in_ctrl),
        .in_data   (bus.in_data),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .load_in   (load_in),
        .load_skid (load_skid),
        .clear_out (clear_out),
        .skid_ctrl (skid_ctrl),
        .skid_data (skid_data)
    );
`else
    logic accept;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    // Flush discards the word accepted in the same cycle.
    assign load_in      = accept & ~flush;
    assign clear_out    = flush | (out_valid_q & bus.out_ready & ~accept);
    assign load_skid    = 1'b0;
    assign skid_ctrl    = '0;
    assign skid_data    = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_BUBBLE;
            out_data_q  <= '0;
        end else if (clear_out) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= CTRL_BUBBLE;
        end else if (load_in) begin
            out_valid_q <= 1'b1;
            out_ctrl_q  <= bus.in_ctrl;
            out_data_q  <= bus.in_data;
        end else if (load_skid) begin
            out_valid_q <= 1'b1;
            out_ctrl_q  <= skid_ctrl;
            out_data_q  <= skid_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid_q && !bus.out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = out_ctrl_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with an in-order scoreboard of accepted words.
// Works for both the base build and PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
    localparam int                CTRL_W = 32;
    localparam int                DATA_W = 128;
    localparam int                CNT_W  = 4;
    localparam logic [CTRL_W-1:0] BUBBLE = 32'h0000_0013;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

    pipe_stage_reg #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .CTRL_BUBBLE (BUBBLE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    word_t sb[$];
    logic  last_acc;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
    endtask

    // One clock: sample handshakes at the falling edge, update the scoreboard after the rising edge.
    task automatic tick();
        logic  acc, drn, fl;
        word_t seen, pend, exp;
        @(negedge clk);
        acc       = bus.in_valid & bus.in_ready;
        drn       = bus.out_valid & bus.out_ready;
        fl        = flush;
        seen.ctrl = bus.out_ctrl;
        seen.data = bus.out_data;
        pend.ctrl = bus.in_ctrl;
        pend.data = bus.in_data;
        @(posedge clk);
        #1;
        if (drn) begin
            check("sb_pop_avail", DATA_W'(sb.size() != 0), DATA_W'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("sb_ctrl", DATA_W'(seen.ctrl), DATA_W'(exp.ctrl));
                check("sb_data", seen.data, exp.data);
            end
        end
        if (fl) sb.delete();
        else if (acc) sb.push_back(pend);
        last_acc = acc & ~fl;
        if (!bus.out_valid) check("nop_invariant", DATA_W'(bus.out_ctrl), DATA_W'(BUBBLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("rst_out_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(BUBBLE));
        check("rst_out_data", bus.out_data, '0);
        check("rst_stall_cnt", DATA_W'(stall_cnt), DATA_W'(0));
        check("rst_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));

        // Streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'hC000_0000 | i, DATA_W'(i));
            tick();
            check("stream_valid", DATA_W'(bus.out_valid), DATA_W'(1));
            check("stream_data", bus.out_data, DATA_W'(i));
        end
        drive(1'b0, '0, '0);
        tick();
        check("stream_end_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("stream_end_data_held", bus.out_data, DATA_W'(4));

        // Backpressure: 0xA held, 0xB waits upstream or in the skid entry
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_00A0, DATA_W'('hA));
        tick();
        check("bp_load_a", bus.out_data, DATA_W'('hA));
        drive(1'b1, 32'h0000_00B0, DATA_W'('hB));
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) drive(1'b0, '0, '0);
        end
        check("bp_hold_data", bus.out_data, DATA_W'('hA));
        check("bp_hold_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(32'h0000_00A0));
        check("bp_stall_cnt", DATA_W'(stall_cnt), DATA_W'(5));
        check("bp_in_ready", DATA_W'(bus.in_ready), DATA_W'(0));
        bus.out_ready = 1'b1;
        tick();
        if (last_acc) drive(1'b0, '0, '0);
        check("bp_release_data", bus.out_data, DATA_W'('hB));
        check("bp_release_valid", DATA_W'(bus.out_valid), DATA_W'(1));
        check("bp_stall_cnt_kept", DATA_W'(stall_cnt), DATA_W'(5));
        drive(1'b0, '0, '0);
        tick();
        check("bp_drained", DATA_W'(bus.out_valid), DATA_W'(0));

        // Flush collides with a valid output and an incoming 0x55
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0033, DATA_W'('h33));
        tick();
        check("fl_load", bus.out_data, DATA_W'('h33));
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        drive(1'b1, 32'h0000_0055, DATA_W'('h55));
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("fl_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(BUBBLE));
        check("fl_data_held", bus.out_data, DATA_W'('h33));
        check("fl_stall_cnt", DATA_W'(stall_cnt), DATA_W'(5));
        tick();
        check("fl_no_55_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("fl_no_55_data", bus.out_data, DATA_W'('h33));

        // Counter saturation after a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        sb.delete();
        check("sat_cleared", DATA_W'(stall_cnt), DATA_W'(0));
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_00D0, DATA_W'('hD));
        tick();
        drive(1'b0, '0, '0);
        for (int i = 0; i < 10; i++) tick();
        check("sat_count_10", DATA_W'(stall_cnt), DATA_W'(10));
        for (int i = 0; i < 10; i++) tick();
        check("sat_count_max", DATA_W'(stall_cnt), DATA_W'(15));
        check("sat_data_held", bus.out_data, DATA_W'('hD));

        // Asynchronous reset between clock edges mid-stall
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", DATA_W'(bus.out_valid), DATA_W'(0));
        check("arst_out_ctrl", DATA_W'(bus.out_ctrl), DATA_W'(BUBBLE));
        check("arst_out_data", bus.out_data, '0);
        check("arst_stall_cnt", DATA_W'(stall_cnt), DATA_W'(0));
        check("arst_in_ready", DATA_W'(bus.in_ready), DATA_W'(1));
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Recovery after reset
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0077, DATA_W'('h77));
        tick();
        check("post_rst_data", bus.out_data, DATA_W'('h77));
        drive(1'b0, '0, '0);
        tick();
        check("sb_empty_at_end", DATA_W'(sb.size()), DATA_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
